// File: rtl/decode_stage.sv
// Registered N-way decode stage for a small Alpha integer subset. In-order instruction-buffer
// lanes are decoded and held in a WAYS-deep queue that dispatch drains oldest first.
package decode_stage_pkg;
    typedef logic [31:0] IBEntry_t;
    typedef logic [4:0]  ARCH_REG;
    localparam ARCH_REG ZERO_REG = 5'd31;

    typedef enum logic [1:0] {FUT_ALU, FUT_MULT, FUT_BR, FUT_LDST} FU_TYPE;
    typedef enum logic {OPA_IS_REGA, OPA_IS_NPC} opa_sel_t;
    typedef enum logic [1:0] {OPB_IS_REGB, OPB_IS_ALU_IMM, OPB_IS_MEM_DISP, OPB_IS_BR_DISP} opb_sel_t;
    typedef enum logic [3:0] {
        ALU_ADDQ, ALU_SUBQ, ALU_AND, ALU_BIS, ALU_XOR, ALU_CMPEQ, ALU_CMPULT, ALU_MULQ
    } alu_func_t;
    typedef enum logic [1:0] {DEST_NONE, DEST_RC, DEST_RA} dest_sel_t;

    typedef struct packed {
        opa_sel_t  opa_select;
        opb_sel_t  opb_select;
        alu_func_t alu_func;
        dest_sel_t dest_reg;
        logic      rd_mem;
        logic      halt;
        logic      illegal;
        logic      noop;
    } DE_control_t;

    typedef struct packed {
        FU_TYPE      fu_type;
        ARCH_REG     dest_idx;
        ARCH_REG     rega_idx;
        ARCH_REG     regb_idx;
        DE_control_t control;
    } de_lane_t;

    localparam de_lane_t EMPTY_LANE = '{
        fu_type: FUT_ALU, dest_idx: ZERO_REG, rega_idx: ZERO_REG, regb_idx: ZERO_REG, control: '0
    };
endpackage

module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int WAYS        = 2,
    parameter bit ENABLE_MULT = 1'b1,
    parameter bit DROP_NOOP   = 1'b0,
    localparam int CW         = $clog2(WAYS + 1)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [WAYS-1:0]      ib_valid,
    input  logic [WAYS*32-1:0]   ib_data,
    input  logic                 flush,
    input  logic [CW-1:0]        dp_accept,
    output logic [CW-1:0]        de_consume,
    output logic [WAYS-1:0]      de_valid,
    output logic [WAYS*2-1:0]    de_fuType,
    output logic [WAYS*5-1:0]    de_destidx,
    output logic [WAYS*5-1:0]    de_regAidx,
    output logic [WAYS*5-1:0]    de_regBidx,
    output logic [WAYS*13-1:0]   de_control,
    output logic                 de_halted,
    output logic                 de_exception
);

    de_lane_t      entries   [WAYS];
    de_lane_t      next_q    [WAYS];
    de_lane_t      new_lanes [WAYS];
    de_lane_t      lane_dec;
    logic [CW-1:0] occ;
    logic [CW-1:0] acc_eff;
    logic          halted;
    logic          exc;
    logic          hit_halt;
    logic          hit_illegal;
    logic          stop;
    int            room;
    int            keep;
    int            enq;
    int            take;

    function automatic de_lane_t decode_lane(input IBEntry_t inst);
        de_lane_t   d;
        logic       legal;
        logic [5:0] op;
        logic [6:0] func;
        op    = inst[31:26];
        func  = inst[11:5];
        legal = 1'b1;
        d     = EMPTY_LANE;
        case (op)
            6'h00: begin
                if (inst[25:0] == 26'd0) d.control.halt = 1'b1;
                else legal = 1'b0;
            end
            6'h10, 6'h11, 6'h13: begin
                d.rega_idx           = inst[25:21];
                d.regb_idx           = inst[12] ? ZERO_REG : inst[20:16];
                d.dest_idx           = inst[4:0];
                d.control.opb_select = inst[12] ? OPB_IS_ALU_IMM : OPB_IS_REGB;
                d.control.dest_reg   = DEST_RC;
                case ({op, func})
                    {6'h10, 7'h20}: d.control.alu_func = ALU_ADDQ;
                    {6'h10, 7'h29}: d.control.alu_func = ALU_SUBQ;
                    {6'h10, 7'h2D}: d.control.alu_func = ALU_CMPEQ;
                    {6'h10, 7'h1D}: d.control.alu_func = ALU_CMPULT;
                    {6'h11, 7'h00}: d.control.alu_func = ALU_AND;
                    {6'h11, 7'h20}: d.control.alu_func = ALU_BIS;
                    {6'h11, 7'h40}: d.control.alu_func = ALU_XOR;
                    {6'h13, 7'h20}: begin
                        d.fu_type          = FUT_MULT;
                        d.control.alu_func = ALU_MULQ;
                        legal              = ENABLE_MULT;
                    end
                    default: legal = 1'b0;
                endcase
                // BIS into r31 is the canonical Alpha NOP and writes nothing.
                if (op == 6'h11 && func == 7'h20 && inst[4:0] == ZERO_REG) begin
                    d.control.noop     = 1'b1;
                    d.control.dest_reg = DEST_NONE;
                    d.dest_idx         = ZERO_REG;
                end
            end
            6'h29: begin
                d.fu_type            = FUT_LDST;
                d.rega_idx           = inst[20:16];
                d.dest_idx           = inst[25:21];
                d.control.opb_select = OPB_IS_MEM_DISP;
                d.control.dest_reg   = DEST_RA;
                d.control.rd_mem     = 1'b1;
            end
            6'h30, 6'h34: begin
                d.fu_type            = FUT_BR;
                d.dest_idx           = inst[25:21];
                d.control.opa_select = OPA_IS_NPC;
                d.control.opb_select = OPB_IS_BR_DISP;
                d.control.dest_reg   = DEST_RA;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            d                 = EMPTY_LANE;
            d.control.illegal = 1'b1;
        end
        return d;
    endfunction

    // Lane selection, take count and the compacted next queue image.
    always_comb begin
        acc_eff     = (dp_accept > occ) ? occ : dp_accept;
        room        = WAYS - int'(occ) + int'(acc_eff);
        keep        = int'(occ) - int'(acc_eff);
        take        = 0;
        enq         = 0;
        stop        = 1'b0;
        hit_halt    = 1'b0;
        hit_illegal = 1'b0;
        lane_dec    = EMPTY_LANE;
        for (int i = 0; i < WAYS; i++) new_lanes[i] = EMPTY_LANE;
        for (int i = 0; i < WAYS; i++) begin
            lane_dec = decode_lane(ib_data[i*32 +: 32]);
            if (stop || !ib_valid[i]) begin
                stop = 1'b1;
            end else if (DROP_NOOP && lane_dec.control.noop) begin
                take = take + 1;
            end else if (enq < room) begin
                new_lanes[enq] = lane_dec;
                enq            = enq + 1;
                take           = take + 1;
                if (lane_dec.control.halt)    hit_halt    = 1'b1;
                if (lane_dec.control.illegal) hit_illegal = 1'b1;
                if (lane_dec.control.halt || lane_dec.control.illegal) stop = 1'b1;
            end else begin
                stop = 1'b1;
            end
        end
        if (!reset_n || flush || halted) begin
            take        = 0;
            enq         = 0;
            hit_halt    = 1'b0;
            hit_illegal = 1'b0;
        end
        for (int i = 0; i < WAYS; i++) begin
            next_q[i] = EMPTY_LANE;
            if (i < keep)            next_q[i] = entries[i + int'(acc_eff)];
            else if (i - keep < enq) next_q[i] = new_lanes[i - keep];
        end
        de_consume = CW'(take);
    end

    // Flush clears the queue image too, so lanes past occ always read as empty.
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            occ    <= '0;
            halted <= 1'b0;
            exc    <= 1'b0;
            for (int i = 0; i < WAYS; i++) entries[i] <= EMPTY_LANE;
        end else begin
            occ <= CW'(keep + enq);
            for (int i = 0; i < WAYS; i++) entries[i] <= next_q[i];
            if (hit_halt || hit_illegal) halted <= 1'b1;
            if (hit_illegal)             exc    <= 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            de_valid[i]            = (i < int'(occ));
            de_fuType[i*2 +: 2]    = entries[i].fu_type;
            de_destidx[i*5 +: 5]   = entries[i].dest_idx;
            de_regAidx[i*5 +: 5]   = entries[i].rega_idx;
            de_regBidx[i*5 +: 5]   = entries[i].regb_idx;
            de_control[i*13 +: 13] = entries[i].control;
        end
        de_halted    = halted;
        de_exception = exc;
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: one instance with default options, one with MULQ disabled
// and NOOP dropping enabled, each checked against hand-computed directed vectors.
module tb_decode_stage;

    typedef struct packed {
        logic [1:0]  fu;
        logic [4:0]  dest;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [12:0] ctrl;
    } laneExp_t;

    typedef struct {
        int         dut;
        string      name;
        logic [1:0] consume;
        logic [1:0] valid;
        laneExp_t   lane0;
        laneExp_t   lane1;
        logic       halted;
        logic       exc;
    } expItem_t;

    // Control word: opa[12] opb[11:10] alu[9:6] dest[5:4] rd_mem[3] halt[2] illegal[1] noop[0].
    localparam logic [12:0] C_ADDQ = 13'h010;
    localparam logic [12:0] C_SUBQ = 13'h050;
    localparam logic [12:0] C_MULQ = 13'h1D0;
    localparam logic [12:0] C_NOOP = 13'h0C1;
    localparam logic [12:0] C_HALT = 13'h004;
    localparam logic [12:0] C_ILL  = 13'h002;

    localparam laneExp_t L_E    = {2'd0, 5'd31, 5'd31, 5'd31, 13'h000};
    localparam laneExp_t L_A    = {2'd0, 5'd3,  5'd1,  5'd2,  C_ADDQ};
    localparam laneExp_t L_B    = {2'd0, 5'd6,  5'd4,  5'd5,  C_ADDQ};
    localparam laneExp_t L_C    = {2'd0, 5'd9,  5'd7,  5'd8,  C_ADDQ};
    localparam laneExp_t L_D    = {2'd0, 5'd12, 5'd10, 5'd11, C_ADDQ};
    localparam laneExp_t L_SUB  = {2'd0, 5'd3,  5'd1,  5'd2,  C_SUBQ};
    localparam laneExp_t L_MUL  = {2'd1, 5'd3,  5'd1,  5'd2,  C_MULQ};
    localparam laneExp_t L_NOOP = {2'd0, 5'd31, 5'd31, 5'd31, C_NOOP};
    localparam laneExp_t L_HALT = {2'd0, 5'd31, 5'd31, 5'd31, C_HALT};
    localparam laneExp_t L_ILL  = {2'd0, 5'd31, 5'd31, 5'd31, C_ILL};

    logic        clock = 1'b0;
    logic        resetN   [2];
    logic        flushIn  [2];
    logic [1:0]  ibValid  [2];
    logic [63:0] ibData   [2];
    logic [1:0]  dpAccept [2];
    logic [1:0]  deConsume[2];
    logic [1:0]  deValid  [2];
    logic [3:0]  deFuType [2];
    logic [9:0]  deDest   [2];
    logic [9:0]  deRegA   [2];
    logic [9:0]  deRegB   [2];
    logic [25:0] deControl[2];
    logic        deHalted [2];
    logic        deExc    [2];

    expItem_t consQ[$];
    expItem_t stateQ[$];
    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] iA, iB, iC, iD, iSub, iMul, iNoop, iHalt;

    always #5 clock = ~clock;

    decode_stage #(.WAYS(2), .ENABLE_MULT(1'b1), .DROP_NOOP(1'b0)) dutA (
        .clock(clock), .reset_n(resetN[0]), .ib_valid(ibValid[0]), .ib_data(ibData[0]),
        .flush(flushIn[0]), .dp_accept(dpAccept[0]), .de_consume(deConsume[0]),
        .de_valid(deValid[0]), .de_fuType(deFuType[0]), .de_destidx(deDest[0]),
        .de_regAidx(deRegA[0]), .de_regBidx(deRegB[0]), .de_control(deControl[0]),
        .de_halted(deHalted[0]), .de_exception(deExc[0])
    );

    decode_stage #(.WAYS(2), .ENABLE_MULT(1'b0), .DROP_NOOP(1'b1)) dutB (
        .clock(clock), .reset_n(resetN[1]), .ib_valid(ibValid[1]), .ib_data(ibData[1]),
        .flush(flushIn[1]), .dp_accept(dpAccept[1]), .de_consume(deConsume[1]),
        .de_valid(deValid[1]), .de_fuType(deFuType[1]), .de_destidx(deDest[1]),
        .de_regAidx(deRegA[1]), .de_regBidx(deRegB[1]), .de_control(deControl[1]),
        .de_halted(deHalted[1]), .de_exception(deExc[1])
    );

    function automatic logic [31:0] mkOp(input logic [5:0] op, input logic [6:0] fn,
                                         input logic [4:0] ra, input logic [4:0] rb,
                                         input logic [4:0] rc);
        return {op, ra, rb, 3'b000, 1'b0, fn, rc};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs on the falling edge and queues what the DUT must show.
    task automatic applyStimulus(input int dut, input string name, input logic rstn, input logic fl,
                                 input logic [1:0] v, input logic [31:0] d1, input logic [31:0] d0,
                                 input logic [1:0] acc, input logic [1:0] expCons,
                                 input logic [1:0] expValid, input laneExp_t e0, input laneExp_t e1,
                                 input logic expH, input logic expE);
        expItem_t it;
        @(negedge clock);
        resetN[dut]   = rstn;
        flushIn[dut]  = fl;
        ibValid[dut]  = v;
        ibData[dut]   = {d1, d0};
        dpAccept[dut] = acc;
        it.dut     = dut;
        it.name    = name;
        it.consume = expCons;
        it.valid   = expValid;
        it.lane0   = e0;
        it.lane1   = e1;
        it.halted  = expH;
        it.exc     = expE;
        consQ.push_back(it);
        stateQ.push_back(it);
    endtask

    // Combinational take count is checked while the inputs of the current cycle are stable.
    initial begin
        expItem_t it;
        forever begin
            @(negedge clock);
            #2;
            if (consQ.size() > 0) begin
                it = consQ.pop_front();
                checkOutput($sformatf("%s/consume", it.name), 64'(deConsume[it.dut]), 64'(it.consume));
            end
        end
    end

    // Registered outputs are checked just after the edge that consumed the queued vector.
    initial begin
        expItem_t it;
        forever begin
            @(posedge clock);
            #1;
            if (stateQ.size() > 0) begin
                it = stateQ.pop_front();
                checkOutput($sformatf("%s/valid", it.name), 64'(deValid[it.dut]), 64'(it.valid));
                checkOutput($sformatf("%s/fuType", it.name), 64'(deFuType[it.dut]),
                            64'({it.lane1.fu, it.lane0.fu}));
                checkOutput($sformatf("%s/destidx", it.name), 64'(deDest[it.dut]),
                            64'({it.lane1.dest, it.lane0.dest}));
                checkOutput($sformatf("%s/regAidx", it.name), 64'(deRegA[it.dut]),
                            64'({it.lane1.ra, it.lane0.ra}));
                checkOutput($sformatf("%s/regBidx", it.name), 64'(deRegB[it.dut]),
                            64'({it.lane1.rb, it.lane0.rb}));
                checkOutput($sformatf("%s/control", it.name), 64'(deControl[it.dut]),
                            64'({it.lane1.ctrl, it.lane0.ctrl}));
                checkOutput($sformatf("%s/halted", it.name), 64'(deHalted[it.dut]), 64'(it.halted));
                checkOutput($sformatf("%s/exception", it.name), 64'(deExc[it.dut]), 64'(it.exc));
            end
        end
    end

    initial begin
        iA    = mkOp(6'h10, 7'h20, 5'd1,  5'd2,  5'd3);
        iB    = mkOp(6'h10, 7'h20, 5'd4,  5'd5,  5'd6);
        iC    = mkOp(6'h10, 7'h20, 5'd7,  5'd8,  5'd9);
        iD    = mkOp(6'h10, 7'h20, 5'd10, 5'd11, 5'd12);
        iSub  = mkOp(6'h10, 7'h29, 5'd1,  5'd2,  5'd3);
        iMul  = mkOp(6'h13, 7'h20, 5'd1,  5'd2,  5'd3);
        iNoop = mkOp(6'h11, 7'h20, 5'd31, 5'd31, 5'd31);
        iHalt = 32'h0000_0000;
        for (int d = 0; d < 2; d++) begin
            resetN[d]   = 1'b0;
            flushIn[d]  = 1'b0;
            ibValid[d]  = 2'b00;
            ibData[d]   = 64'd0;
            dpAccept[d] = 2'd0;
        end

        applyStimulus(0, "a_reset",          1'b0, 1'b0, 2'b11, iB, iA,    2'd2, 2'd0, 2'b00, L_E,    L_E,    1'b0, 1'b0);
        applyStimulus(0, "a_fill",           1'b1, 1'b0, 2'b11, iB, iA,    2'd2, 2'd2, 2'b11, L_A,    L_B,    1'b0, 1'b0);
        applyStimulus(0, "a_stream1",        1'b1, 1'b0, 2'b11, iD, iC,    2'd2, 2'd2, 2'b11, L_C,    L_D,    1'b0, 1'b0);
        applyStimulus(0, "a_stream2",        1'b1, 1'b0, 2'b11, iB, iA,    2'd2, 2'd2, 2'b11, L_A,    L_B,    1'b0, 1'b0);
        applyStimulus(0, "a_full_hold",      1'b1, 1'b0, 2'b11, iD, iC,    2'd0, 2'd0, 2'b11, L_A,    L_B,    1'b0, 1'b0);
        applyStimulus(0, "a_partial",        1'b1, 1'b0, 2'b11, iD, iC,    2'd1, 2'd1, 2'b11, L_B,    L_C,    1'b0, 1'b0);
        applyStimulus(0, "a_clamp",          1'b1, 1'b0, 2'b00, iD, iC,    2'd3, 2'd0, 2'b00, L_E,    L_E,    1'b0, 1'b0);
        applyStimulus(0, "a_mult",           1'b1, 1'b0, 2'b11, iA, iMul,  2'd2, 2'd2, 2'b11, L_MUL,  L_A,    1'b0, 1'b0);
        applyStimulus(0, "a_halt",           1'b1, 1'b0, 2'b11, iB, iHalt, 2'd2, 2'd1, 2'b01, L_HALT, L_E,    1'b1, 1'b0);
        applyStimulus(0, "a_halted_hold",    1'b1, 1'b0, 2'b11, iB, iA,    2'd0, 2'd0, 2'b01, L_HALT, L_E,    1'b1, 1'b0);
        applyStimulus(0, "a_halted_drain",   1'b1, 1'b0, 2'b11, iB, iA,    2'd1, 2'd0, 2'b00, L_E,    L_E,    1'b1, 1'b0);
        applyStimulus(0, "a_flush_clear",    1'b1, 1'b1, 2'b11, iB, iA,    2'd2, 2'd0, 2'b00, L_E,    L_E,    1'b0, 1'b0);
        applyStimulus(0, "a_refill",         1'b1, 1'b0, 2'b11, iB, iA,    2'd0, 2'd2, 2'b11, L_A,    L_B,    1'b0, 1'b0);
        applyStimulus(0, "a_flush_dispatch", 1'b1, 1'b1, 2'b11, iD, iC,    2'd2, 2'd0, 2'b00, L_E,    L_E,    1'b0, 1'b0);
        applyStimulus(0, "a_lane1_invalid",  1'b1, 1'b0, 2'b01, iB, iA,    2'd0, 2'd1, 2'b01, L_A,    L_E,    1'b0, 1'b0);
        applyStimulus(0, "a_gap",            1'b1, 1'b0, 2'b10, iD, iC,    2'd0, 2'd0, 2'b01, L_A,    L_E,    1'b0, 1'b0);
        applyStimulus(0, "a_halt_fills",     1'b1, 1'b0, 2'b11, iB, iHalt, 2'd0, 2'd1, 2'b11, L_A,    L_HALT, 1'b1, 1'b0);
        applyStimulus(0, "a_reset_priority", 1'b0, 1'b1, 2'b11, iB, iA,    2'd2, 2'd0, 2'b00, L_E,    L_E,    1'b0, 1'b0);
        applyStimulus(0, "a_noop_kept",      1'b1, 1'b0, 2'b11, iC, iNoop, 2'd0, 2'd2, 2'b11, L_NOOP, L_C,    1'b0, 1'b0);

        applyStimulus(1, "b_reset",          1'b0, 1'b0, 2'b00, iB, iA,    2'd0, 2'd0, 2'b00, L_E,    L_E,    1'b0, 1'b0);
        applyStimulus(1, "b_drop_noop",      1'b1, 1'b0, 2'b11, iSub, iNoop, 2'd0, 2'd2, 2'b01, L_SUB, L_E,   1'b0, 1'b0);
        applyStimulus(1, "b_illegal_mulq",   1'b1, 1'b0, 2'b11, iA, iMul,  2'd1, 2'd1, 2'b01, L_ILL,  L_E,    1'b1, 1'b1);
        applyStimulus(1, "b_halted_hold",    1'b1, 1'b0, 2'b11, iB, iA,    2'd0, 2'd0, 2'b01, L_ILL,  L_E,    1'b1, 1'b1);
        applyStimulus(1, "b_flush",          1'b1, 1'b1, 2'b11, iB, iA,    2'd0, 2'd0, 2'b00, L_E,    L_E,    1'b0, 1'b0);
        applyStimulus(1, "b_all_noop",       1'b1, 1'b0, 2'b11, iNoop, iNoop, 2'd0, 2'd2, 2'b00, L_E,  L_E,    1'b0, 1'b0);
        applyStimulus(1, "b_fill",           1'b1, 1'b0, 2'b11, iB, iA,    2'd0, 2'd2, 2'b11, L_A,    L_B,    1'b0, 1'b0);
        applyStimulus(1, "b_noop_no_room",   1'b1, 1'b0, 2'b11, iC, iNoop, 2'd0, 2'd1, 2'b11, L_A,    L_B,    1'b0, 1'b0);

        repeat (3) @(negedge clock);
        vectors++;
        if (consQ.size() != 0 || stateQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: %0d/%0d entries left, expected 0/0",
                     consQ.size(), stateQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, registered N-way decode stage between the instruction buffer and dispatch. Each cycle it takes up to WAYS in-order instruction-buffer entries, decodes them per lane, and stores them in a WAYS-deep output queue. Dispatch drains this queue partially, oldest first. The stage optionally drops NOOPs, gates multiply support, and latches halt/illegal conditions until a flush.

## Interface
- WAYS, 2: lanes per cycle and output-queue depth (≥1).
- ENABLE_MULT, 1: 0 makes MULQ decode illegal.
- DROP_NOOP, 0: 1 consumes NOOP lanes without enqueuing them.
- CW = $clog2(WAYS+1): width of the count ports.
- clock  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- ib_valid  in  WAYS  per-lane entry valid; lane 0 is oldest.
- ib_data  in  WAYS×IBEntry_t  instruction-buffer entries.
- flush  in  1  branch-recovery flush.
- dp_accept  in  CW  number of oldest queue entries dispatch takes this cycle.
- de_consume  out  CW  combinational; number of ib lanes taken this cycle.
- de_valid  out  WAYS  registered thermometer; lane i valid iff i < occ.
- de_fuType, de_destidx, de_regAidx, de_regBidx, de_control  out  WAYS×(FU_TYPE, ARCH_REG×3, DE_control_t)  registered per-lane decode.
- de_halted  out  1  registered; a halt or illegal has been taken.
- de_exception  out  1  registered; the latched stop was caused by an illegal instruction.

## Operation
- Per-lane decode uses the team's Alpha subset rules: ALU, MULT, BR, and LDST FU types; dest/A/B index selection; and opa/opb/alu_func/dest_reg/rd_mem/halt/illegal/noop. With ENABLE_MULT=0, MULQ sets illegal.
- State: occ (0..WAYS), queue[WAYS], halted, exc.
- dp_acc_eff = min(dp_accept, occ). An out-of-range dp_accept is clamped, not an error.
- room = WAYS − occ + dp_acc_eff.
- cand = leading contiguous lanes with ib_valid=1. The first invalid lane ends cand.
- Cand is truncated after the first lane that is halt or illegal; that lane is included.
- take = number of cand lanes taken in order until enqueued entries would exceed room. With DROP_NOOP=1, noop lanes count toward take but not toward room.
- de_consume = take. It is 0 when halted=1, flush=1, or reset_n=0.
- Next queue state:
  - Shift remaining entries down by dp_acc_eff.
  - Append the taken non-dropped lanes in order.
  - occ' = occ − dp_acc_eff + enqueued.
- If a taken lane is halt: halted'=1. If a taken lane is illegal: halted'=1, exc'=1. A halt/illegal lane is itself enqueued.
- While halted, take=0. Dispatch may still drain the queue.
- flush=1:
  - occ'=0, halted'=0, exc'=0, de_consume=0.
  - dp_accept is ignored.
  - Flush takes priority over every other event.
- de_valid and all per-lane outputs come directly from the queue registers. Lanes ≥ occ drive de_valid=0 and zeroed fields: DEST_NONE, ZERO_REG, FUT_ALU, all control flags 0.

## Timing
- Reset (reset_n=0 at an edge):
  - occ=0, halted=0, exc=0, all queue lanes zeroed.
  - de_valid=0, de_halted=0, de_exception=0.
  - de_consume=0 combinationally while reset_n=0.
- Latency: an entry taken at edge t appears on de_* after edge t (1 cycle).
- The same cycle may dispatch and refill. A full queue (occ=WAYS) with dp_accept=WAYS accepts WAYS new lanes.
- Empty queue: dp_accept is clamped to 0.
- Full queue with dp_accept=0: de_consume=0 and the queue holds unchanged.
- Halt in lane k: lanes >k are not consumed. From the next cycle de_consume=0 until flush.
- Reset asserted mid-operation discards the queue and halt state at that edge, regardless of flush or dp_accept.
- The instruction buffer must advance by exactly de_consume lanes each cycle. de_consume depends combinationally on ib_valid, ib_data, dp_accept, and flush. It has no path from the outputs.

## Test plan
- Reset then steady stream (WAYS=2): two valid ADDQ lanes every cycle, dp_accept=2. Expect de_consume=2 each cycle, de_valid=2'b11 from cycle 2, alu_func ADDQ, dest=rc.
- Partial drain and compaction: queue full with {A,B}; dp_accept=1; ib lanes {C,D}. Expect de_consume=1 and next queue {B,C}.
- Halt mid-group: lane0 HALT, lane1 ADDQ. Expect de_consume=1, then de_halted=1 and de_consume=0 while ib stays valid. flush=1 then clears de_halted and occ.
- Illegal and mode: ENABLE_MULT=0 with MULQ in lane0. Expect illegal=1 in lane0 control, de_exception=1, and de_fuType FUT_MULT not issued.
- DROP_NOOP=1: lanes {NOOP, SUBQ} with an empty queue. Expect de_consume=2, occ=1, de_valid=2'b01, lane0 SUBQ.
- Flush vs. dispatch and reset priority: flush=1 with dp_accept=2 and valid ib lanes. Expect de_consume=0 and de_valid=0 next cycle. Then reset_n=0 with halted=1: all outputs zero after the edge.
